sar_search_ctrl: RTL
====================

Name: sar_search_ctrl

Overview:
- Initiator-side controller for the team's 16-bit magnitude comparator.
- Drives a trial value (probe) into the comparator and reads back its signed 2-bit verdict.
- Runs an MSB-first successive-approximation binary search that recovers the unknown operand on the comparator's other input (target) in WIDTH steps.
- Used for threshold discovery and ADC-style SAR loops; the comparator itself stays combinational or externally registered.

Parameters:
- WIDTH, 16, operand and search width in bits.
- CMP_LAT, 0, comparator latency in clock cycles from probe change to valid cmp_res; legal range 0..7.

Ports:
- clk      input   1      rising-edge clock
- rst_n    input   1      asynchronous active-low reset
- start    input   1      request a new search; sampled only in IDLE
- cmp_res  input   2      signed comparator verdict: 2'sb01 = target >= probe, 2'sb11 = target < probe
- probe    output  WIDTH  trial value driven to the comparator's in2
- busy     output  1      high while a search is in progress
- done     output  1      one-cycle pulse when a search finishes (normal or error)
- result   output  WIDTH  recovered target value; held until the next accepted start
- err      output  1      set with done if an illegal cmp_res code was seen; cleared on the next accepted start

Behaviour:
- Reset: clk and rst_n are the single clock and the asynchronous active-low reset. Asserting rst_n low forces state IDLE and clears probe, busy, done, result, err, the accumulator, the bit index and the wait counter to 0. This applies at any time, including mid-search; no done pulse is issued for an aborted search.
- States:
  - IDLE: waiting for start.
  - TRIAL: probe = acc | (1 << idx).
  - WAIT: hold probe for CMP_LAT cycles.
  - FINISH: emit the done pulse.
- IDLE -> TRIAL when start=1 at a clock edge:
  - acc <= 0, idx <= WIDTH-1, err <= 0, busy <= 1.
  - result keeps its old value until FINISH.
- Per bit, the probe is held constant for CMP_LAT+1 cycles. cmp_res is sampled at the edge ending the last of those cycles.
  - CMP_LAT=0: TRIAL samples directly.
  - CMP_LAT>0: TRIAL -> WAIT, with a counter running CMP_LAT cycles; the last WAIT edge samples.
- Decision at the sample edge:
  - 2'sb01: acc[idx] <= 1 (keep the bit).
  - 2'sb11: acc[idx] <= 0.
  - 2'b00 or 2'b10: err <= 1, go to FINISH immediately; result <= acc as it stood (partial).
- After the idx=0 decision, go to FINISH. Otherwise idx decrements and the state returns to TRIAL.
- FINISH (one cycle), then IDLE:
  - done=1, busy=0, result = final acc.
- Timing:
  - busy is high for exactly WIDTH*(CMP_LAT+1) cycles.
  - done is asserted in the cycle immediately after busy falls.
  - Latency from the start edge to the done cycle is WIDTH*(CMP_LAT+1)+1 cycles.
- probe is 0 in IDLE and FINISH.
- A start seen during TRIAL, WAIT or FINISH is ignored and not queued. A start held high continuously relaunches on the first IDLE cycle.
- Equal target and probe yields 2'sb01, so the bit is kept. A correct comparator therefore always gives result == target.
- Boundary values: target 0 clears every bit; target 2^WIDTH-1 keeps every bit. No overflow is possible since acc is WIDTH bits.

Decomposition:
- Shared package:
  - CMP_GE = 2'sb01 and CMP_LT = 2'sb11.
  - The state enum {IDLE, TRIAL, WAIT, FINISH}.
  - Width of the wait counter, $clog2(CMP_LAT+1) with a minimum of 1.
- No sub-module is warranted. The FSM, accumulator, index and wait counter form a single module.
- The bench instantiates the existing comparator as the responder. For CMP_LAT>0 it adds a CMP_LAT-stage register pipeline on cmp_res.

Test Plan:
- CMP_LAT=0, target=16'hA5C3, one-cycle start:
  - busy high 16 cycles; done pulse at cycle 17; result=16'hA5C3; err=0.
  - probe sequence starts 16'h8000, 16'hC000, 16'hA000.
- Targets 16'h0000 and 16'hFFFF:
  - result equals target.
  - Last probe is 16'h0001 and 16'hFFFF respectively.
- CMP_LAT=2 with a 2-stage registered comparator, target=16'h1234:
  - busy high 48 cycles; result=16'h1234.
  - Each probe value stable for 3 cycles.
- Force cmp_res=2'b00 at the idx=7 sample, target=16'hFF00:
  - done and err assert one cycle later; result=16'hFF00 (bits 15..8 kept, lower bits 0).
  - The next start clears err.
- Pulse start again at cycle 5 of a search:
  - Ignored; done occurs once at the nominal cycle.
  - Continuous start high gives back-to-back searches separated by FINISH and one IDLE cycle.
- Assert rst_n low at cycle 9 of a search:
  - All outputs 0 immediately (asynchronous); no done pulse.
  - After release, a fresh start with target=16'h0F0F returns 16'h0F0F.

Source files
------------

// File: rtl/sar_search_ctrl_pkg.sv
// rtl/sar_search_ctrl_pkg.sv - shared verdict codes, FSM states and sizing helper for the SAR search controller
package sar_search_ctrl_pkg;

  localparam logic signed [1:0] CMP_GE = 2'sb01;
  localparam logic signed [1:0] CMP_LT = 2'sb11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIAL  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Wait counter must hold values up to CMP_LAT, and never collapse to zero bits.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - MSB-first successive-approximation search driving a magnitude comparator
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CMP_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [1:0]       cmp_res,
  output logic        [WIDTH-1:0] probe,
  output logic                    busy,
  output logic                    done,
  output logic        [WIDTH-1:0] result,
  output logic                    err
);

  localparam int              CW       = cnt_width(CMP_LAT);
  localparam int              IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);
  localparam logic [IW-1:0]   TOP_IDX  = IW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [WIDTH-1:0] w_bit;
  logic             w_sample;
  logic             w_keep;
  logic             w_legal;

  assign w_bit   = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;
  assign w_keep  = (cmp_res == CMP_GE);
  assign w_legal = w_keep || (cmp_res == CMP_LT);

  // The verdict is taken on the edge ending the CMP_LAT+1'th cycle of a stable probe.
  always_comb begin
    w_sample = 1'b0;
    case (r_state)
      TRIAL:   w_sample = (CMP_LAT == 0);
      WAIT:    w_sample = (r_cnt == LAST_CNT);
      default: w_sample = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (start) w_next = TRIAL;
      TRIAL, WAIT: begin
        if (w_sample) w_next = (!w_legal || r_idx == '0) ? FINISH : TRIAL;
        else          w_next = WAIT;
      end
      FINISH:      w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_idx <= TOP_IDX;
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        TRIAL, WAIT: begin
          r_cnt <= (r_state == TRIAL) ? '0 : r_cnt + 1'b1;
          if (w_sample) begin
            if (!w_legal) begin
              r_err    <= 1'b1;
              r_result <= r_acc;
            end else begin
              r_acc[r_idx] <= w_keep;
              if (r_idx == '0) r_result <= w_keep ? (r_acc | w_bit) : (r_acc & ~w_bit);
              else             r_idx    <= r_idx - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    probe = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      TRIAL, WAIT: begin
        probe = r_acc | w_bit;
        busy  = 1'b1;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign result = r_result;
  assign err    = r_err;

endmodule
